code_transmitter: RTL and testbench

CODE_TRANSMITTER -- requirements
Module: code_transmitter

---
 rtl/code_transmitter.sv | 108 ++++++++++
 tb/tb_code_transmitter.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/code_transmitter.sv
// Serial codeword transmitter: DEPTH-entry input FIFO feeding a start-bit + MSB-first framer.
// Frames are WIDTH+1 cycles with no stop bit; back-to-back frames leave no idle gap.
module code_transmitter #(
  parameter int WIDTH = 7,
  parameter int DEPTH = 4
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic [WIDTH-1:0]         io_input,
  input  logic                     io_valid,
  output logic                     io_ready,
  output logic                     io_output,
  output logic                     io_busy,
  output logic [$clog2(DEPTH):0]   io_level
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = PTR_W + 1;
  localparam int CNT_W = $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE, START, DATA} state_t;

  state_t             state, state_nxt;
  logic [WIDTH-1:0]   mem [DEPTH];
  logic [PTR_W-1:0]   wr_ptr, rd_ptr;
  logic [WIDTH-1:0]   shift_q, shift_nxt;
  logic [CNT_W-1:0]   cnt_q, cnt_nxt;
  logic               out_nxt;
  logic               push, pop;

  // Ready depends only on the registered level, so a full FIFO never accepts
  // a word even on the edge that frees a slot.
  assign io_ready = io_level < LVL_W'(DEPTH);
  assign push     = io_valid && io_ready;
  assign io_busy  = (state != IDLE);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    shift_nxt = shift_q;
    cnt_nxt   = cnt_q;
    out_nxt   = 1'b0;
    pop       = 1'b0;
    case (state)
      IDLE: begin
        if (io_level != '0) begin
          pop       = 1'b1;
          shift_nxt = mem[rd_ptr];
          out_nxt   = 1'b1;
          state_nxt = START;
        end
      end
      START: begin
        out_nxt   = shift_q[WIDTH-1];
        shift_nxt = shift_q << 1;
        cnt_nxt   = CNT_W'(WIDTH - 1);
        state_nxt = DATA;
      end
      DATA: begin
        // cnt_q is the index of the bit currently on the line
        if (cnt_q != '0) begin
          out_nxt   = shift_q[WIDTH-1];
          shift_nxt = shift_q << 1;
          cnt_nxt   = cnt_q - CNT_W'(1);
        end else if (io_level != '0) begin
          pop       = 1'b1;
          shift_nxt = mem[rd_ptr];
          out_nxt   = 1'b1;
          state_nxt = START;
        end else begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      io_output <= 1'b0;
      shift_q   <= '0;
      cnt_q     <= '0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      io_level  <= '0;
    end else begin
      io_output <= out_nxt;
      shift_q   <= shift_nxt;
      cnt_q     <= cnt_nxt;
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   io_level <= io_level + LVL_W'(1);
        2'b01:   io_level <= io_level - LVL_W'(1);
        default: io_level <= io_level;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (push) mem[wr_ptr] <= io_input;
  end

endmodule

// File: tb/tb_code_transmitter.sv
// Directed bench for code_transmitter: reset, single/back-to-back frames, full FIFO,
// simultaneous push/pop, asynchronous reset mid-frame and the all-zero word.
module tb_code_transmitter;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic [6:0] io_input = '0;
  logic       io_valid = 1'b0;
  logic       io_ready, io_output, io_busy;
  logic [2:0] io_level;

  int n_chk  = 0;
  int n_fail = 0;

  logic [6:0] a_word = 7'h11;
  logic [6:0] fw [7] = '{7'h33, 7'h44, 7'h55, 7'h66, 7'h66, 7'h66, 7'h66};
  logic [6:0] mid_word = 7'h5A;

  always #5 clock = ~clock;

  code_transmitter #(.WIDTH(7), .DEPTH(4)) dut (
    .clock    (clock),
    .reset    (reset),
    .io_input (io_input),
    .io_valid (io_valid),
    .io_ready (io_ready),
    .io_output(io_output),
    .io_busy  (io_busy),
    .io_level (io_level)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Checks the start bit in the current cycle, then the 7 data bits MSB-first.
  task automatic send_check(input logic [6:0] w, input string tag);
    chk({tag, " start"}, io_output, 1);
    chk({tag, " busy"}, io_busy, 1);
    for (int i = 6; i >= 0; i--) begin
      tick();
      chk({tag, " bit"}, io_output, w[i]);
      chk({tag, " busy"}, io_busy, 1);
    end
  endtask

  initial begin
    // reset state, pushes ignored while in reset
    io_valid = 1'b1;
    io_input = 7'h7F;
    #1;
    chk("rst out", io_output, 0);
    chk("rst busy", io_busy, 0);
    chk("rst level", io_level, 0);
    chk("rst ready", io_ready, 1);
    tick();
    tick();
    chk("rst no push", io_level, 0);
    chk("rst out held", io_output, 0);
    io_valid = 1'b0;
    reset = 1'b1;
    tick();
    tick();
    chk("idle out", io_output, 0);
    chk("idle busy", io_busy, 0);
    chk("idle level", io_level, 0);

    // single word
    io_input = 7'b1011001;
    io_valid = 1'b1;
    tick();
    io_valid = 1'b0;
    chk("single queued", io_level, 1);
    chk("single no bypass", io_output, 0);
    chk("single not busy", io_busy, 0);
    tick();
    chk("single popped", io_level, 0);
    send_check(7'h59, "single");
    tick();
    chk("single end out", io_output, 0);
    chk("single end busy", io_busy, 0);
    tick();
    chk("single idle", io_output, 0);

    // back-to-back
    io_input = 7'h59;
    io_valid = 1'b1;
    tick();
    io_input = 7'h26;
    tick();
    io_valid = 1'b0;
    chk("b2b level", io_level, 1);
    send_check(7'h59, "b2b first");
    tick();
    send_check(7'h26, "b2b second");
    chk("b2b drained", io_level, 0);
    tick();
    chk("b2b end out", io_output, 0);
    chk("b2b end busy", io_busy, 0);

    // full FIFO while frame A is in flight
    io_input = a_word;
    io_valid = 1'b1;
    tick();
    chk("full lvl0", io_level, 1);
    io_input = 7'h22;
    tick();
    chk("full A start", io_output, 1);
    chk("full lvl1", io_level, 1);
    chk("full rdy1", io_ready, 1);
    for (int k = 0; k < 7; k++) begin
      int lvl;
      io_input = fw[k];
      tick();
      lvl = (k + 2 > 4) ? 4 : k + 2;
      chk("full A bit", io_output, a_word[6-k]);
      chk("full level", io_level, lvl);
      chk("full ready", io_ready, (lvl < 4) ? 1 : 0);
    end
    // frame end with level 4: pop only
    tick();
    chk("full pop lvl", io_level, 3);
    chk("full pop ready", io_ready, 1);
    io_valid = 1'b0;
    send_check(7'h22, "full B");
    // frame end with level 3 and a push: level unchanged
    io_input = 7'h77;
    io_valid = 1'b1;
    tick();
    io_valid = 1'b0;
    chk("pushpop level", io_level, 3);
    send_check(7'h33, "full C");
    tick();
    send_check(7'h44, "full D");
    tick();
    send_check(7'h55, "full E");
    tick();
    send_check(7'h77, "full G");
    tick();
    chk("full end out", io_output, 0);
    chk("full end busy", io_busy, 0);
    chk("full end level", io_level, 0);

    // asynchronous reset during data bit 3 with two words queued
    io_input = mid_word;
    io_valid = 1'b1;
    tick();
    io_input = 7'h3C;
    tick();
    io_input = 7'h0F;
    tick();
    io_valid = 1'b0;
    chk("mid queued", io_level, 2);
    tick();
    tick();
    tick();
    chk("mid bit3", io_output, mid_word[3]);
    chk("mid busy", io_busy, 1);
    #2 reset = 1'b0;
    #1;
    chk("async out", io_output, 0);
    chk("async level", io_level, 0);
    chk("async busy", io_busy, 0);
    chk("async ready", io_ready, 1);
    @(posedge clock);
    #1;
    reset = 1'b1;
    for (int i = 0; i < 12; i++) begin
      tick();
      chk("post rst out", io_output, 0);
      chk("post rst busy", io_busy, 0);
    end
    chk("post rst level", io_level, 0);

    // all-zero word, also first push after reset release
    io_input = 7'h00;
    io_valid = 1'b1;
    tick();
    io_valid = 1'b0;
    chk("zero queued", io_level, 1);
    chk("zero no bypass", io_output, 0);
    tick();
    send_check(7'h00, "zero");
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("zero idle out", io_output, 0);
      chk("zero idle busy", io_busy, 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
